// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer logic for the async FIFO: synchronizes the write Gray pointer and derives empty, almost-empty, fill count and underflow.
// Define FIFO_RD_SYNC3_EN to use a three-flop write-pointer synchronizer (status latency 4 edges instead of 3).
module fifo_rd_ptr_empty #(
  parameter int PTR_W     = 12,
  parameter int AE_THRESH = 4
) (
  input  logic             i_rd_clk,
  input  logic             i_rd_rst,
  input  logic             i_rd_en,
  input  logic [PTR_W:0]   i_wr_ptr_gray,
  output logic [PTR_W:0]   o_rd_ptr_gray,
  output logic [PTR_W-1:0] o_rd_addr,
  output logic             o_empty,
  output logic             o_almost_empty,
  output logic [PTR_W:0]   o_rd_count,
  output logic             o_underflow
);

  localparam logic [PTR_W:0] AE_LIM = (PTR_W+1)'(AE_THRESH);

  logic [PTR_W:0] sq1_q, sq2_q, sq_last;
  logic [PTR_W:0] wq_bin;
  logic [PTR_W:0] rd_bin_q, rd_bin_d;
  logic [PTR_W:0] rd_gray_q, rd_gray_d;
  logic [PTR_W:0] count_q, count_d;
  logic           empty_q, empty_d;
  logic           ae_q, ae_d;
  logic           uf_q, uf_d;
  logic           rd_ok;

  // Plain flop chain: the write pointer is Gray coded, so at most one bit is in flight.
  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      sq1_q <= '0;
      sq2_q <= '0;
    end else begin
      sq1_q <= i_wr_ptr_gray;
      sq2_q <= sq1_q;
    end
  end

`ifdef FIFO_RD_SYNC3_EN
  logic [PTR_W:0] sq3_q;

  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      sq3_q <= '0;
    end else begin
      sq3_q <= sq2_q;
    end
  end

  assign sq_last = sq3_q;
`else
  assign sq_last = sq2_q;
`endif

  always_comb begin
    wq_bin = '0;
    for (int i = 0; i <= PTR_W; i++) begin
      wq_bin[i] = ^(sq_last >> i);
    end
  end

  // Status is computed from the post-read pointer so a read at edge N updates empty at that same edge.
  always_comb begin
    rd_ok     = i_rd_en & ~empty_q;
    rd_bin_d  = rd_bin_q + {{PTR_W{1'b0}}, rd_ok};
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    empty_d   = (rd_gray_d == sq_last);
    count_d   = wq_bin - rd_bin_d;
    ae_d      = (count_d <= AE_LIM);
    uf_d      = i_rd_en & empty_q;
  end

  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      ae_q      <= 1'b1;
      uf_q      <= 1'b0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      ae_q      <= ae_d;
      uf_q      <= uf_d;
    end
  end

  assign o_rd_ptr_gray  = rd_gray_q;
  assign o_rd_addr      = rd_bin_q[PTR_W-1:0];
  assign o_empty        = empty_q;
  assign o_almost_empty = ae_q;
  assign o_rd_count     = count_q;
  assign o_underflow    = uf_q;

endmodule
